// File: rtl/soc_ascon_enc_wrapper.sv
// -----------------------------------------------------------------------------
// soc_ascon_enc_wrapper
//
// Purpose:
//   SoC-facing wrapper around an Ascon AEAD encryption datapath. Key, nonce,
//   associated data and plaintext are loaded one byte lane each per load
//   strobe, encryption is launched through a gated start strobe, and the
//   ciphertext followed by the 128-bit tag is read back one byte per strobe.
//   The Ascon sponge (one permutation round per clock) lives in this file.
//
// Optional feature macro:
//   PT_READBACK_EN - when defined, plaintextxSO mirrors the top 32 bits of
//                    the plaintext register; when undefined it is tied to 0.
//
// Ports:
//   clk                  clock, all logic on the rising edge
//   rst                  synchronous active-high reset
//   reg_inputxSS         load strobe
//   inputxSI[31:0]       load word {PT byte, AD byte, nonce byte, key byte}
//   reg_startxSS         start register select
//   encryption_startxSI  start request (effective only with reg_startxSS)
//   encryption_readyxSO  sticky encryption-complete flag
//   reg_outxSS           output read strobe
//   cipher_tagxSO[7:0]   output byte ({CT, TAG}, MSB first)
//   plaintextxSO[31:0]   plaintext readback (zero unless PT_READBACK_EN)
//
// Parameter constraints: k in {128, 160}, r in {64, 128}, a and b <= 12,
// l and y multiples of 8 and non-zero.
// -----------------------------------------------------------------------------
module soc_ascon_enc_wrapper #(
    parameter int k = 128,
    parameter int r = 64,
    parameter int a = 12,
    parameter int b = 6,
    parameter int l = 40,
    parameter int y = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_inputxSS,
    input  logic [31:0] inputxSI,
    input  logic        reg_startxSS,
    input  logic        encryption_startxSI,
    output logic        encryption_readyxSO,
    input  logic        reg_outxSS,
    output logic [7:0]  cipher_tagxSO,
    output logic [31:0] plaintextxSO
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int KB   = k / 8;
    localparam int NB   = 16;
    localparam int LB   = l / 8;
    localparam int YB   = y / 8;
    localparam int MKL  = (k > l) ? k : l;
    localparam int MY   = (MKL > y) ? MKL : y;
    localparam int M    = ((MY > 128) ? MY : 128) / 8;   // load beats
    localparam int IW   = $clog2(M + 1);
    localparam int OB   = YB + 16;                       // readable bytes
    localparam int JW   = $clog2(OB + 1);
    // Padding always appends at least one bit, hence the +1 block.
    localparam int ADN  = l / r + 1;
    localparam int ADP  = ADN * r;
    localparam int PTN  = y / r + 1;
    localparam int PTP  = PTN * r;
    localparam int YR   = y % r;
    localparam int BN   = (ADN > PTN) ? ADN : PTN;
    localparam int BW   = $clog2(BN + 1);
    localparam int IVW  = 192 - k;
    localparam logic [IVW-1:0] IV =
        IVW'({8'(k), 8'(r), 8'(a), 8'(b)}) << (IVW - 32);

    // ------------------------------------------------------------------
    // Ascon permutation round (bitsliced S-box + linear diffusion)
    // ------------------------------------------------------------------
    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s,
                                                 input logic [3:0]   idx);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        // Round constant: high nibble counts down as the low nibble counts up.
        x2 = x2 ^ {56'd0, ~idx, idx};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // ------------------------------------------------------------------
    // Wrapper registers
    // ------------------------------------------------------------------
    logic [k-1:0]   key_q,   key_d;
    logic [127:0]   nonce_q, nonce_d;
    logic [l-1:0]   ad_q,    ad_d;
    logic [y-1:0]   pt_q,    pt_d;
    logic [IW-1:0]  i_q;
    logic [JW-1:0]  j_q;
    logic           start_q;
    logic           ready_q;
    logic [7:0]     cipher_q;
    logic [y-1:0]   ct_q;
    logic [127:0]   tag_q;

    // ------------------------------------------------------------------
    // Core registers
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        C_IDLE,
        C_INIT,
        C_AD,
        C_PT,
        C_PTPERM,
        C_FIN
    } core_st_t;

    core_st_t       cst_q;
    logic [319:0]   s_q;
    logic [3:0]     rnd_q;
    logic [BW-1:0]  blk_q;
    logic           core_done_q;
    logic [y-1:0]   ct_core_q;
    logic [127:0]   tag_core_q;

    // ------------------------------------------------------------------
    // Strobe qualification
    // ------------------------------------------------------------------
    logic start_req_w;
    logic busy_w;
    logic load_en_w;

    assign start_req_w = reg_startxSS & encryption_startxSI;
    // Busy spans the start register, every core phase and the done pulse,
    // so the key/data registers are stable for the whole computation.
    assign busy_w      = start_q | (cst_q != C_IDLE) | core_done_q;
    // A start request in the same cycle takes priority over a load.
    assign load_en_w   = reg_inputxSS & (i_q < IW'(M)) & ~start_req_w & ~busy_w;

    // Byte-lane next-state: beat gi writes byte gi (MSB first) of each field.
    genvar gi;
    generate
        for (gi = 0; gi < KB; gi++) begin : g_key
            assign key_d[k-1-8*gi -: 8] = (load_en_w && i_q == IW'(gi)) ?
                                          inputxSI[7:0] : key_q[k-1-8*gi -: 8];
        end
        for (gi = 0; gi < NB; gi++) begin : g_nonce
            assign nonce_d[127-8*gi -: 8] = (load_en_w && i_q == IW'(gi)) ?
                                            inputxSI[15:8] : nonce_q[127-8*gi -: 8];
        end
        for (gi = 0; gi < LB; gi++) begin : g_ad
            assign ad_d[l-1-8*gi -: 8] = (load_en_w && i_q == IW'(gi)) ?
                                         inputxSI[23:16] : ad_q[l-1-8*gi -: 8];
        end
        for (gi = 0; gi < YB; gi++) begin : g_pt
            assign pt_d[y-1-8*gi -: 8] = (load_en_w && i_q == IW'(gi)) ?
                                         inputxSI[31:24] : pt_q[y-1-8*gi -: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Core datapath helpers
    // ------------------------------------------------------------------
    logic [3:0]     idx_w;
    logic [319:0]   perm_w;
    logic [ADP-1:0] ad_pad_w;
    logic [PTP-1:0] pt_pad_w;
    logic [BW-1:0]  ad_idx_w;
    logic [r-1:0]   ad_blk_w;
    logic [r-1:0]   pt_blk_w;
    logic [r-1:0]   c_w;
    logic [319:0]   init_mix_w;
    logic [319:0]   fin_mix_w;
    logic [319:0]   rate_ad_w;
    logic           ad_last_w;
    logic           pt_last_w;
    logic [7:0]     byte_w;

    // rnd_q counts remaining rounds; p^n uses the last n of 12 constants.
    assign idx_w      = 4'd12 - rnd_q;
    assign perm_w     = ascon_round(s_q, idx_w);

    // 10* padding of AD and PT out to a whole number of rate blocks.
    assign ad_pad_w   = ADP'({ad_q, 1'b1}) << (ADP - l - 1);
    assign pt_pad_w   = PTP'({pt_q, 1'b1}) << (PTP - y - 1);

    assign ad_last_w  = (blk_q == BW'(ADN - 1));
    assign pt_last_w  = (blk_q == BW'(PTN - 1));

    // During INIT the first AD block is absorbed; during AD the next one.
    always_comb begin
        ad_idx_w = '0;
        if (cst_q == C_AD && !ad_last_w) begin
            ad_idx_w = blk_q + BW'(1);
        end
    end

    assign ad_blk_w   = r'(ad_pad_w >> (ADP - r - r * int'(ad_idx_w)));
    assign pt_blk_w   = r'(pt_pad_w >> (PTP - r - r * int'(blk_q)));
    assign c_w        = s_q[319 -: r] ^ pt_blk_w;
    assign rate_ad_w  = {ad_blk_w, {(320 - r){1'b0}}};
    assign init_mix_w = {{(320 - k){1'b0}}, key_q};
    assign fin_mix_w  = {{r{1'b0}}, key_q, {(320 - r - k){1'b0}}};

    // Output byte j of {CT, TAG}, MSB first.
    assign byte_w     = 8'({ct_q, tag_q} >> (y + 120 - 8 * int'(j_q)));

    // ------------------------------------------------------------------
    // Core sequencer: one permutation round per clock
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cst_q       <= C_IDLE;
            s_q         <= '0;
            rnd_q       <= '0;
            blk_q       <= '0;
            core_done_q <= 1'b0;
            ct_core_q   <= '0;
            tag_core_q  <= '0;
        end else begin
            core_done_q <= 1'b0;
            case (cst_q)
                C_IDLE: begin
                    if (start_q) begin
                        s_q   <= {IV, key_q, nonce_q};
                        rnd_q <= 4'(a);
                        cst_q <= C_INIT;
                    end
                end
                C_INIT: begin
                    rnd_q <= rnd_q - 4'd1;
                    if (rnd_q == 4'd1) begin
                        s_q   <= perm_w ^ init_mix_w ^ rate_ad_w;
                        blk_q <= '0;
                        rnd_q <= 4'(b);
                        cst_q <= C_AD;
                    end else begin
                        s_q <= perm_w;
                    end
                end
                C_AD: begin
                    rnd_q <= rnd_q - 4'd1;
                    if (rnd_q == 4'd1) begin
                        if (ad_last_w) begin
                            // Domain separation between AD and message.
                            s_q   <= perm_w ^ 320'd1;
                            blk_q <= '0;
                            cst_q <= C_PT;
                        end else begin
                            s_q   <= perm_w ^ rate_ad_w;
                            blk_q <= blk_q + BW'(1);
                            rnd_q <= 4'(b);
                        end
                    end else begin
                        s_q <= perm_w;
                    end
                end
                C_PT: begin
                    if (pt_last_w) begin
                        // Last block: only the top YR bits are ciphertext;
                        // the padding bits of c_w are shifted away.
                        s_q       <= {c_w, s_q[319-r:0]} ^ fin_mix_w;
                        ct_core_q <= y'({ct_core_q, c_w} >> (r - YR));
                        rnd_q     <= 4'(a);
                        cst_q     <= C_FIN;
                    end else begin
                        s_q       <= {c_w, s_q[319-r:0]};
                        ct_core_q <= y'({ct_core_q, c_w});
                        rnd_q     <= 4'(b);
                        cst_q     <= C_PTPERM;
                    end
                end
                C_PTPERM: begin
                    rnd_q <= rnd_q - 4'd1;
                    s_q   <= perm_w;
                    if (rnd_q == 4'd1) begin
                        blk_q <= blk_q + BW'(1);
                        cst_q <= C_PT;
                    end
                end
                C_FIN: begin
                    rnd_q <= rnd_q - 4'd1;
                    s_q   <= perm_w;
                    if (rnd_q == 4'd1) begin
                        tag_core_q  <= perm_w[127:0] ^ key_q[127:0];
                        core_done_q <= 1'b1;
                        cst_q       <= C_IDLE;
                    end
                end
                default: cst_q <= C_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register interface: load, start, completion, readout
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q    <= '0;
            nonce_q  <= '0;
            ad_q     <= '0;
            pt_q     <= '0;
            i_q      <= '0;
            j_q      <= '0;
            start_q  <= 1'b0;
            ready_q  <= 1'b0;
            cipher_q <= '0;
            ct_q     <= '0;
            tag_q    <= '0;
        end else begin
            start_q <= start_req_w;
            key_q   <= key_d;
            nonce_q <= nonce_d;
            ad_q    <= ad_d;
            pt_q    <= pt_d;
            if (load_en_w) begin
                i_q <= i_q + IW'(1);
            end
            if (start_req_w) begin
                ready_q <= 1'b0;
                j_q     <= '0;
            end else begin
                if (core_done_q) begin
                    ready_q <= 1'b1;
                    ct_q    <= ct_core_q;
                    tag_q   <= tag_core_q;
                end
                if (reg_outxSS && ready_q) begin
                    if (j_q < JW'(OB)) begin
                        cipher_q <= byte_w;
                        j_q      <= j_q + JW'(1);
                    end else begin
                        cipher_q <= 8'h00;
                    end
                end
            end
        end
    end

    assign encryption_readyxSO = ready_q;
    assign cipher_tagxSO       = cipher_q;

`ifdef PT_READBACK_EN
    logic [31:0] pt_rb_q;
    logic [31:0] pt_top_w;

    generate
        if (y >= 32) begin : g_rb_wide
            assign pt_top_w = pt_q[y-1 -: 32];
        end else begin : g_rb_narrow
            assign pt_top_w = {pt_q, {(32 - y){1'b0}}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pt_rb_q <= '0;
        end else begin
            pt_rb_q <= pt_top_w;
        end
    end

    assign plaintextxSO = pt_rb_q;
`else
    assign plaintextxSO = '0;
`endif

endmodule

// File: tb/tb_soc_ascon_enc_wrapper.sv
// -----------------------------------------------------------------------------
// tb_soc_ascon_enc_wrapper
//
// Directed bench for soc_ascon_enc_wrapper with default parameters
// (Ascon-128, AD and PT of 5 bytes). Expected ciphertext/tag come from a
// behavioural Ascon model that uses the 5-bit S-box lookup table.
// -----------------------------------------------------------------------------
module tb_soc_ascon_enc_wrapper;

    logic        clk;
    logic        rst;
    logic        reg_inputxSS;
    logic [31:0] inputxSI;
    logic        reg_startxSS;
    logic        encryption_startxSI;
    logic        encryption_readyxSO;
    logic        reg_outxSS;
    logic [7:0]  cipher_tagxSO;
    logic [31:0] plaintextxSO;

    int checks = 0;
    int errors = 0;

    soc_ascon_enc_wrapper dut (
        .clk                 (clk),
        .rst                 (rst),
        .reg_inputxSS        (reg_inputxSS),
        .inputxSI            (inputxSI),
        .reg_startxSS        (reg_startxSS),
        .encryption_startxSI (encryption_startxSI),
        .encryption_readyxSO (encryption_readyxSO),
        .reg_outxSS          (reg_outxSS),
        .cipher_tagxSO       (cipher_tagxSO),
        .plaintextxSO        (plaintextxSO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    // Entry v sits at bits [5v+4 -: 5]; listed from entry 31 down to 0.
    localparam logic [159:0] SBOX = {
        5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
        5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
        5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
        5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04};

    function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] m_perm(input logic [319:0] s, input int nr);
        logic [63:0]  x [5];
        logic [159:0] sb;
        logic [4:0]   col;
        logic [4:0]   o;
        sb = SBOX;
        for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
        for (int rr = 12 - nr; rr < 12; rr++) begin
            x[2] = x[2] ^ 64'((15 - rr) * 16 + rr);
            for (int bi = 0; bi < 64; bi++) begin
                col = {x[0][bi], x[1][bi], x[2][bi], x[3][bi], x[4][bi]};
                o = sb[5*col +: 5];
                x[0][bi] = o[4];
                x[1][bi] = o[3];
                x[2][bi] = o[2];
                x[3][bi] = o[1];
                x[4][bi] = o[0];
            end
            x[0] = x[0] ^ m_ror(x[0], 19) ^ m_ror(x[0], 28);
            x[1] = x[1] ^ m_ror(x[1], 61) ^ m_ror(x[1], 39);
            x[2] = x[2] ^ m_ror(x[2], 1)  ^ m_ror(x[2], 6);
            x[3] = x[3] ^ m_ror(x[3], 10) ^ m_ror(x[3], 17);
            x[4] = x[4] ^ m_ror(x[4], 7)  ^ m_ror(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    // Returns {CT(40), TAG(128)}.
    function automatic logic [167:0] m_encrypt(input logic [127:0] key,
                                               input logic [127:0] nonce,
                                               input logic [39:0]  ad,
                                               input logic [39:0]  pt);
        logic [319:0] s;
        logic [39:0]  ct;
        s = {64'h80400c0600000000, key, nonce};
        s = m_perm(s, 12);
        s[127:0] = s[127:0] ^ key;
        s[319:256] = s[319:256] ^ {ad, 8'h80, 16'h0000};
        s = m_perm(s, 6);
        s[0] = s[0] ^ 1'b1;
        s[319:256] = s[319:256] ^ {pt, 8'h80, 16'h0000};
        ct = s[319:280];
        s[255:128] = s[255:128] ^ key;
        s = m_perm(s, 12);
        return {ct, s[127:0] ^ key};
    endfunction

    // ------------------------------------------------------------------
    // Vector tables
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] word;
        logic [31:0] exp_pt;
    } load_vec_t;

    typedef struct {
        int         idx;
        logic [7:0] exp_byte;
    } read_vec_t;

    load_vec_t lv [16];
    read_vec_t rv [22];

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic load_beat(input logic [31:0] word, input logic [31:0] exp_pt,
                             input string name);
        reg_inputxSS = 1'b1;
        inputxSI     = word;
        tick();
        reg_inputxSS = 1'b0;
        inputxSI     = '0;
        tick();
        check(name, plaintextxSO, exp_pt);
    endtask

    task automatic load_all();
        for (int n = 0; n < 16; n++) begin
            load_beat(lv[n].word, lv[n].exp_pt, $sformatf("load_beat%0d_pt", n));
        end
    endtask

    task automatic pulse_start();
        reg_startxSS        = 1'b1;
        encryption_startxSI = 1'b1;
        tick();
        reg_startxSS        = 1'b0;
        encryption_startxSI = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (encryption_readyxSO) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic read_byte(input logic [7:0] exp, input string name);
        reg_outxSS = 1'b1;
        tick();
        reg_outxSS = 1'b0;
        check(name, 32'(cipher_tagxSO), 32'(exp));
    endtask

    task automatic read_all(input string tag);
        for (int n = 0; n < 22; n++) begin
            read_byte(rv[n].exp_byte, $sformatf("%s_byte%0d", tag, rv[n].idx));
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [167:0] ref_ct_tag;
        logic [7:0]   pt_n;
        logic [31:0]  e;
        logic [31:0]  exp_after;

        rst                 = 1'b1;
        reg_inputxSS        = 1'b0;
        inputxSI            = '0;
        reg_startxSS        = 1'b0;
        encryption_startxSI = 1'b0;
        reg_outxSS          = 1'b0;

        ref_ct_tag = m_encrypt(128'h000102030405060708090a0b0c0d0e0f,
                               128'h000102030405060708090a0b0c0d0e0f,
                               40'h0001020304, 40'h0001020304);

        // Beat n: {PT_n, AD_n, n, n}; AD/PT lanes beyond byte 4 carry junk.
        for (int n = 0; n < 16; n++) begin
            pt_n = (n < 5) ? 8'(n) : 8'hEE;
            lv[n].word = {pt_n, (n < 5) ? 8'(n) : 8'hDD, 8'(n), 8'(n)};
            e = '0;
`ifdef PT_READBACK_EN
            for (int jj = 0; jj < 4; jj++) begin
                if (jj <= n) e[31 - 8*jj -: 8] = 8'(jj);
            end
`endif
            lv[n].exp_pt = e;
        end
        for (int n = 0; n < 22; n++) begin
            rv[n].idx      = n;
            rv[n].exp_byte = (n < 21) ? ref_ct_tag[167 - 8*n -: 8] : 8'h00;
        end
`ifdef PT_READBACK_EN
        exp_after = 32'h00010203;
`else
        exp_after = 32'h0;
`endif

        // Reset
        idle(2);
        rst = 1'b0;
        check("reset_ready", 32'(encryption_readyxSO), 32'd0);
        check("reset_cipher", 32'(cipher_tagxSO), 32'd0);
        check("reset_pt", plaintextxSO, 32'd0);

        // Read strobes before ready change nothing
        read_byte(8'h00, "early_read0");
        read_byte(8'h00, "early_read1");

        // Load 16 beats plus an ignored 17th
        load_all();
        load_beat(32'hFFFF_FFFF, exp_after, "load_beat16_ignored");

        // Request without register select must not start the core
        encryption_startxSI = 1'b1;
        tick();
        encryption_startxSI = 1'b0;
        idle(60);
        check("ungated_start_ready", 32'(encryption_readyxSO), 32'd0);

        // Real start
        pulse_start();
        check("start_ready_low", 32'(encryption_readyxSO), 32'd0);
        wait_ready("run1_ready");
        idle(10);
        check("ready_sticky", 32'(encryption_readyxSO), 32'd1);

        // Readout including the saturated trailing byte
        read_all("run1");
        read_byte(8'h00, "run1_saturated_extra");

        // Reset in the middle of an encryption
        pulse_start();
        idle(10);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(60);
        check("midreset_ready", 32'(encryption_readyxSO), 32'd0);
        check("midreset_cipher", 32'(cipher_tagxSO), 32'd0);

        // Reload and restart
        load_all();
        pulse_start();
        wait_ready("run2_ready");
        read_byte(rv[0].exp_byte, "run2_first_byte");

        // Read and start together: start wins, output byte holds
        reg_outxSS          = 1'b1;
        reg_startxSS        = 1'b1;
        encryption_startxSI = 1'b1;
        tick();
        reg_outxSS          = 1'b0;
        reg_startxSS        = 1'b0;
        encryption_startxSI = 1'b0;
        check("read_start_ready", 32'(encryption_readyxSO), 32'd0);
        check("read_start_cipher", 32'(cipher_tagxSO), 32'(rv[0].exp_byte));

        wait_ready("run3_ready");
        read_all("run3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_ascon_enc_wrapper.md
Name: soc_ascon_enc_wrapper

Overview:
- SoC-facing wrapper around the codebase's existing Ascon AEAD encryption core.
- Key, nonce, associated data and plaintext are loaded byte-serially through one 32-bit word per strobe.
- Encryption is started through a gated start strobe.
- Ciphertext followed by tag is read back one byte per strobe.
- Sits between a PicoSoC-style register interface and the Ascon core.

Parameters:
k, 128, key length in bits (multiple of 8)
r, 64, Ascon rate in bits (passed to core)
a, 12, initialisation/finalisation permutation rounds (passed to core)
b, 6, intermediate permutation rounds (passed to core)
l, 40, associated-data length in bits (multiple of 8)
y, 40, plaintext/ciphertext length in bits (multiple of 8)
Derived constant: M = max(k, l, y, 128)/8, the number of load beats.

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
reg_inputxSS  in  1  load strobe
inputxSI  in  32  load word: [31:24] PT byte, [23:16] AD byte, [15:8] nonce byte, [7:0] key byte
reg_startxSS  in  1  start register select
encryption_startxSI  in  1  start request
encryption_readyxSO  out  1  encryption complete
reg_outxSS  in  1  output read strobe
cipher_tagxSO  out  8  output byte
plaintextxSO  out  32  plaintext readback (optional feature)

Behaviour:
- Reset (rst=1 at clk edge) clears:
  - key, nonce, AD and PT registers;
  - load index i and read index j;
  - encryption_readyxSO, cipher_tagxSO and plaintextxSO;
  - core start.
  - Reset mid-operation aborts the core and holds start low.
- Load, every edge with reg_inputxSS=1 and i<M:
  - key[k-1-8i -: 8] <= inputxSI[7:0], only if 8i <= k-1;
  - nonce[127-8i -: 8] <= inputxSI[15:8], only if 8i <= 127;
  - AD[l-1-8i -: 8] <= inputxSI[23:16], only if 8i <= l-1;
  - PT[y-1-8i -: 8] <= inputxSI[31:24], only if 8i <= y-1;
  - i <= i+1.
  - Byte lanes out of range are ignored.
  - With i==M, further load strobes are ignored and i saturates.
  - Loading is MSB byte first.
- Start:
  - The core start input is a register set when reg_startxSS & encryption_startxSI, cleared otherwise.
  - encryption_startxSI alone has no effect.
  - On the start edge, encryption_readyxSO <= 0 and j <= 0.
  - Load is ignored while the core is busy (after start, before ready).
- Completion:
  - encryption_readyxSO rises one cycle after the core's done.
  - It stays high (sticky) until reset or the next start.
  - Ciphertext (y bits) and tag (128 bits) are latched from the core at done.
- Read, every edge with reg_outxSS=1 and encryption_readyxSO=1:
  - cipher_tagxSO <= byte j of {CT, TAG}, MSB first; j < y/8 selects CT bytes, the next 16 beats select tag bytes;
  - j <= j+1.
  - For j >= y/8+16, output 8'h00 and j saturates.
  - Read strobes while not ready leave cipher_tagxSO and j unchanged.
- Simultaneous load and start: start wins, load ignored. Simultaneous read and start: start wins.
- Latency: one edge from strobe to updated register/output. Core latency is per the core.

Optional Feature:
PT_READBACK_EN
- Defined: plaintextxSO is registered as PT[y-1 -: 32], zero-padded on the right when y<32. It updates one cycle after each load.
- Undefined: plaintextxSO is constant 0 and no readback logic is synthesised.

Test Plan:
- Reset: rst=1 for 2 cycles -> all outputs 0, i=j=0, encryption_readyxSO=0.
- Load: 16 beats with key=nonce=000102..0F, AD=0001020304, PT=0001020304 (beat n word = {PT_n,AD_n,n,n}) -> key/nonce registers = 000102..0F, AD/PT = 0001020304. With PT_READBACK_EN, plaintextxSO=00010203. A 17th beat is ignored.
- Gated start: encryption_startxSI=1 with reg_startxSS=0 -> no start. Both high -> core runs, encryption_readyxSO rises once, sticky.
- Readout: y/8+17 = 22 read strobes -> bytes 0..4 equal the reference-model Ascon CT, bytes 5..20 equal the tag, byte 21 = 00.
- Read strobe before ready -> cipher_tagxSO stays 00, j stays 0.
- rst asserted mid-encryption -> encryption_readyxSO stays 0. A reload plus restart yields the same CT/tag as the readout case.
